// File: rtl/keyfreq_pkg.sv
// Shared types and constants for the key-driven blink-frequency family.
package keyfreq_pkg;

  // Conversion sequencer phases: divide, binary-to-BCD, load result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    BCD  = 2'd2,
    LOAD = 2'd3
  } conv_state_e;

  localparam int DIV_W      = 17;
  localparam int BCD_DIGITS = 4;
  localparam int BCD_W      = 4 * BCD_DIGITS;

  // Key bit positions inside key_state.
  localparam int K_SLOW = 0;
  localparam int K_FAST = 5;

  // Elaboration-time BCD encoding, used for the reset value of the display word.
  function automatic logic [BCD_W-1:0] to_bcd(input int unsigned value);
    int unsigned v;
    logic [BCD_W-1:0] r;
    v = value;
    r = '0;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_div_bcd.sv
// Sequential DIVIDEND / divisor restoring divider followed by a double-dabble
// binary-to-BCD pass. Handshake: a 1-clk start pulse latches divisor and begins
// a run; start while busy aborts the run in progress and restarts with the new
// divisor. done pulses for 1 clk in the same cycle bcd first shows the result;
// an aborted run never pulses done and never touches bcd.
module seq_div_bcd
  import keyfreq_pkg::*;
#(
  parameter int               CW       = 10,
  parameter int               DIVIDEND = 100000,
  parameter logic [BCD_W-1:0] BCD_RST  = 16'h0100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CW-1:0]     divisor,
  output logic              busy,
  output logic              done,
  output logic [BCD_W-1:0]  bcd,
  output conv_state_e       state_dbg
);

  localparam logic [DIV_W-1:0] DVD  = DIV_W'(DIVIDEND);
  localparam logic [4:0]       LAST = 5'(DIV_W - 1);

  conv_state_e      state;
  conv_state_e      state_nxt;
  logic [4:0]       cnt;
  logic [CW-1:0]    div_q;
  logic [CW-1:0]    rem;
  logic [DIV_W-1:0] quo;
  logic [BCD_W-1:0] acc;
  logic [BCD_W-1:0] acc_adj;
  logic [CW:0]      rem_sh;
  logic [CW:0]      rem_diff;
  logic             rem_ge;
  logic             unused_bits;

  // Restoring-divider trial subtraction for the current quotient bit.
  always_comb begin
    rem_sh   = {rem, quo[DIV_W-1]};
    rem_diff = rem_sh - {1'b0, div_q};
    rem_ge   = (rem_sh >= {1'b0, div_q});
  end

  // Double-dabble digit correction: add 3 to every digit that is 5 or more.
  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  // Top bits that only fall out of the arithmetic (result always < 10000).
  assign unused_bits = &{1'b0, rem_diff[CW], acc_adj[BCD_W-1]};

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM next state: start always (re)enters DIV, otherwise phases run to completion.
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = DIV;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        DIV:     if (cnt == LAST) state_nxt = BCD;
        BCD:     if (cnt == LAST) state_nxt = LOAD;
        LOAD:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    busy      = (state != IDLE);
    state_dbg = state;
  end

  // Divider and BCD datapath; one quotient bit or one dabble shift per clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      div_q <= '0;
      rem   <= '0;
      quo   <= '0;
      acc   <= '0;
    end else if (start) begin
      cnt   <= '0;
      div_q <= divisor;
      rem   <= '0;
      quo   <= DVD;
      acc   <= '0;
    end else begin
      case (state)
        DIV: begin
          quo <= {quo[DIV_W-2:0], rem_ge};
          rem <= rem_ge ? rem_diff[CW-1:0] : rem_sh[CW-1:0];
          cnt <= (cnt == LAST) ? 5'd0 : cnt + 5'd1;
        end
        BCD: begin
          {acc, quo} <= {acc_adj[BCD_W-2:0], quo, 1'b0};
          cnt        <= (cnt == LAST) ? 5'd0 : cnt + 5'd1;
        end
        default: ;
      endcase
    end
  end

  // Result register and completion pulse; skipped when a restart lands on LOAD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd  <= BCD_RST;
      done <= 1'b0;
    end else begin
      done <= (state == LOAD) && !start;
      if ((state == LOAD) && !start) bcd <= acc;
    end
  end

endmodule

// File: rtl/freq_cfg_ctrl.sv
// Key-driven blink-period controller: key edge detect, pending press flags,
// saturating cycle register, tick-driven blink counter and the display conversion.
module freq_cfg_ctrl
  import keyfreq_pkg::*;
#(
  parameter int CW       = 10,
  parameter int CYC_RST  = 1000,
  parameter int CYC_MIN  = 100,
  parameter int CYC_MAX  = 1000,
  parameter int CYC_STEP = 100,
  parameter int SCALE    = 100000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick,
  input  logic [5:0]    key_state,
  output logic [CW-1:0] cycle,
  output logic          blink,
  output logic [15:0]   bcd,
  output logic          bcd_upd,
  output logic          busy
);

  localparam logic [CW-1:0]    CYC_RST_V  = CW'(CYC_RST);
  localparam logic [CW:0]      CYC_MIN_V  = (CW+1)'(CYC_MIN);
  localparam logic [CW:0]      CYC_MAX_V  = (CW+1)'(CYC_MAX);
  localparam logic [CW:0]      CYC_STEP_V = (CW+1)'(CYC_STEP);
  localparam logic [BCD_W-1:0] BCD_RST    = to_bcd(SCALE / CYC_RST);

  // A zero cycle would make the divider meaningless.
  if (CYC_MIN < 1) begin : g_cyc_min_check
    $error("freq_cfg_ctrl: CYC_MIN must be at least 1");
  end

  logic [5:0]    key_q;
  logic          press_slow;
  logic          press_fast;
  logic          pend_slow;
  logic          pend_fast;
  logic [CW:0]   cyc_inc;
  logic [CW:0]   cyc_dec;
  logic          can_slow;
  logic          can_fast;
  logic          cyc_change;
  logic [CW-1:0] cnt;
  logic          start_q;
  conv_state_e   conv_state;
  logic          unused_sink;

  // Press detection and saturation checks; one extra bit catches wrap before compare.
  always_comb begin
    press_slow = key_q[K_SLOW] & ~key_state[K_SLOW];
    press_fast = key_q[K_FAST] & ~key_state[K_FAST];
    cyc_inc    = {1'b0, cycle} + CYC_STEP_V;
    cyc_dec    = {1'b0, cycle} - CYC_STEP_V;
    can_slow   = pend_slow & ~pend_fast & (cyc_inc <= CYC_MAX_V);
    can_fast   = pend_fast & ~pend_slow & ~cyc_dec[CW] & (cyc_dec >= CYC_MIN_V);
    cyc_change = tick & (can_slow | can_fast);
  end

  // Key history and pending flags; a press coinciding with a tick waits for the next tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_q     <= 6'h3F;
      pend_slow <= 1'b0;
      pend_fast <= 1'b0;
    end else begin
      key_q <= key_state;
      if (tick) begin
        pend_slow <= press_slow;
        pend_fast <= press_fast;
      end else begin
        pend_slow <= pend_slow | press_slow;
        pend_fast <= pend_fast | press_fast;
      end
    end
  end

  // Cycle register; a real change requests a conversion on the following clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle   <= CYC_RST_V;
      start_q <= 1'b1;
    end else begin
      start_q <= cyc_change;
      if (cyc_change) cycle <= can_slow ? cyc_inc[CW-1:0] : cyc_dec[CW-1:0];
    end
  end

  // Blink half-period counter, advanced only on ticks; a cycle change restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      blink <= 1'b0;
    end else if (tick) begin
      if (cyc_change) begin
        cnt <= '0;
      end else if (cnt == cycle - CW'(1)) begin
        cnt   <= '0;
        blink <= ~blink;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  seq_div_bcd #(
    .CW       (CW),
    .DIVIDEND (SCALE),
    .BCD_RST  (BCD_RST)
  ) u_conv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_q),
    .divisor   (cycle),
    .busy      (busy),
    .done      (bcd_upd),
    .bcd       (bcd),
    .state_dbg (conv_state)
  );

  // Ignored key bits and the conversion phase are kept only for observation.
  assign unused_sink = &{1'b0, key_q[4:1], conv_state};

endmodule

// File: tb/tb_freq_cfg_ctrl.sv
// Bench for freq_cfg_ctrl: directed scenarios plus randomized keys/ticks against
// an integer model of the key/cycle/blink/conversion rules.
module tb_freq_cfg_ctrl;

  localparam int SCALE = 100000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tick;
  logic [5:0]  key_state;
  logic [9:0]  cycle;
  logic        blink;
  logic [15:0] bcd;
  logic        bcd_upd;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_q[$];

  // reference model state
  int          m_cycle, m_cnt, m_edge, m_conv_start, m_conv_val;
  bit          m_blink, m_pend_s, m_pend_f, m_start_next, m_conv_on, m_upd;
  logic [15:0] m_bcd;
  logic [5:0]  m_prev_key;

  // clock / reset block
  always #5 clk = ~clk;

  freq_cfg_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .key_state (key_state),
    .cycle     (cycle),
    .blink     (blink),
    .bcd       (bcd),
    .bcd_upd   (bcd_upd),
    .busy      (busy)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, obs, obs, exp, exp, $time);
  endtask

  function automatic logic [15:0] ref_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic model_reset();
    m_cycle = 1000; m_cnt = 0; m_edge = 0; m_blink = 0;
    m_pend_s = 0; m_pend_f = 0; m_start_next = 1;
    m_conv_on = 0; m_upd = 0; m_conv_start = 0; m_conv_val = 0;
    m_bcd = 16'h0100; m_prev_key = 6'h3F;
    exp_q.delete();
  endtask

  // one rising edge worth of behaviour with the given inputs
  task automatic model_edge(input logic t, input logic [5:0] k);
    int old;
    bit ps, pf, chg;
    m_edge++;
    m_upd = 0;
    if (m_start_next) begin
      m_conv_on = 1; m_conv_start = m_edge; m_conv_val = SCALE / m_cycle;
    end else if (m_conv_on && (m_edge - m_conv_start == 35)) begin
      m_conv_on = 0; m_bcd = ref_bcd(m_conv_val); m_upd = 1;
      exp_q.push_back(m_bcd);
    end
    ps = m_prev_key[0] && !k[0];
    pf = m_prev_key[5] && !k[5];
    m_prev_key = k;
    chg = 0;
    if (t) begin
      old = m_cycle;
      if (m_pend_s && !m_pend_f && m_cycle + 100 <= 1000) begin
        m_cycle += 100; chg = 1;
      end else if (m_pend_f && !m_pend_s && m_cycle - 100 >= 100) begin
        m_cycle -= 100; chg = 1;
      end
      if (chg) m_cnt = 0;
      else if (m_cnt + 1 == old) begin m_cnt = 0; m_blink = !m_blink; end
      else m_cnt++;
      m_pend_s = ps; m_pend_f = pf;
    end else begin
      m_pend_s = m_pend_s | ps; m_pend_f = m_pend_f | pf;
    end
    m_start_next = chg;
  endtask

  // scoreboard: every output against the model, update values through exp_q
  task automatic check_outputs();
    check("cycle", cycle, m_cycle);
    check("blink", blink, m_blink);
    check("busy", busy, m_conv_on);
    check("bcd_upd", bcd_upd, m_upd);
    check("bcd", bcd, m_bcd);
    if (bcd_upd) begin
      if (exp_q.size() == 0) check("upd_unexpected", 1, 0);
      else check("upd_value", bcd, exp_q.pop_front());
    end
  endtask

  // driver: called at a falling edge, returns at the next falling edge
  task automatic step(input logic t, input logic [5:0] k);
    tick = t;
    key_state = k;
    model_edge(t, k);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 6'h3F);
  endtask

  task automatic press(input int idx);
    logic [5:0] k;
    k = 6'h3F;
    k[idx] = 1'b0;
    step(1'b0, k);
    step(1'b0, 6'h3F);
  endtask

  task automatic press_tick(input int idx);
    press(idx);
    step(1'b1, 6'h3F);
  endtask

  task automatic do_reset();
    tick = 1'b0;
    key_state = 6'h3F;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_outputs();
  endtask

  initial begin
    logic [5:0] k;
    int pulses;
    rst_n = 1'b0;
    tick = 1'b0;
    key_state = 6'h3F;
    @(negedge clk);
    do_reset();

    // power-up conversion
    idle(40);
    check("t1_bcd", bcd, 16'h0100);
    check("t1_cycle", cycle, 1000);

    // one faster step
    press_tick(5);
    idle(40);
    check("t2_cycle", cycle, 900);
    check("t2_bcd", bcd, 16'h0111);

    // saturation at the top
    press_tick(0);
    idle(40);
    press_tick(0);
    idle(40);
    check("t3_cycle", cycle, 1000);

    // both keys cancel, next tick unchanged
    press(0);
    press(5);
    step(1'b1, 6'h3F);
    step(1'b1, 6'h3F);
    idle(40);
    check("t4_cycle", cycle, 1000);

    // run down to the minimum, then one more
    for (int i = 0; i < 9; i++) begin
      press_tick(5);
      idle(40);
    end
    check("t5_cycle", cycle, 100);
    check("t5_bcd", bcd, 16'h1000);
    press_tick(5);
    idle(40);
    check("t5_sat", cycle, 100);

    // restart mid-conversion: exactly one update
    pulses = 0;
    press_tick(0);
    for (int i = 0; i < 10; i++) begin step(1'b0, 6'h3F); pulses += int'(bcd_upd); end
    press_tick(0);
    for (int i = 0; i < 45; i++) begin step(1'b0, 6'h3F); pulses += int'(bcd_upd); end
    check("abort_pulses", pulses, 1);
    check("abort_bcd", bcd, 16'h0333);

    // blink period 200, then change part way through a half-period
    press_tick(5);
    for (int i = 0; i < 350; i++) step(1'b1, 6'h3F);
    press(0);
    for (int i = 0; i < 700; i++) step(1'b1, 6'h3F);

    // reset in the middle of a conversion
    press_tick(5);
    idle(10);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_bcd", bcd, 16'h0100);
    check("rst_cycle", cycle, 1000);
    check("rst_blink", blink, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_outputs();

    // randomized keys and ticks
    k = 6'h3F;
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 5) == 0) k[0] = ~k[0];
      if ($urandom_range(0, 5) == 0) k[5] = ~k[5];
      k[4:1] = 4'($urandom_range(0, 15));
      step(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, k);
    end
    idle(40);
    check("exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
